// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential RV32M multiply/divide unit
//
// Purpose:
//   Iterative multiplier (shift-add, one multiplier bit per cycle) and
//   restoring divider (one quotient bit per cycle) for the RV32M funct3
//   operations. Operands are reduced to magnitudes on acceptance; the sign
//   fixup and result-field selection happen in one extra cycle after the
//   last iteration, so a full operation shows resp_valid after the 33rd
//   edge following acceptance.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   synchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  request can be accepted (IDLE, no flush, not in reset)
//   op[2:0]     in   funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   a, b        in   rs1 / rs2 operands
//   flush       in   abort any operation, no response
//   resp_valid  out  result available (DONE only)
//   resp_ready  in   consumer takes result
//   result      out  registered operation result
//   busy        out  high whenever not IDLE
//
// Configuration:
//   MULDIV_EARLY_OUT_EN  when defined, divide-by-zero, signed divide
//                        overflow and multiplies by zero skip iteration and
//                        respond after the first edge following acceptance.

module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;          // negate product / quotient
  logic                rem_neg_q, rem_neg_d;  // negate remainder (sign of a)
  logic [XLEN-1:0]     opnd_q, opnd_d;        // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;          // MUL: {hi, multiplier}; DIV: {rem, quot}
  logic [4:0]          cnt_q, cnt_d;
  logic                fix_q, fix_d;          // iterations finished, fixup pending
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode at acceptance time.
  logic            sgn_a, sgn_b;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            b_zero;

  // One iteration of each algorithm.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  // Sign fixup and field selection.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

`ifdef MULDIV_EARLY_OUT_EN
  logic              early_hit;
  logic [2*XLEN-1:0] early_acc;
`endif

  always_comb begin
    sgn_a  = (op == 3'b001) || (op == 3'b010) || (op[2] && !op[0]);
    sgn_b  = (op == 3'b001) || (op[2] && !op[0]);
    a_neg  = sgn_a && a[XLEN-1];
    b_neg  = sgn_b && b[XLEN-1];
    a_mag  = a_neg ? (~a + 1'b1) : a;
    b_mag  = b_neg ? (~b + 1'b1) : b;
    b_zero = (b == '0);
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Early accumulator contents are chosen so the normal fixup path yields
  // the architectural result: b==0 gives all-ones quotient and |a| as the
  // remainder; overflow gives quotient magnitude 2^(XLEN-1), remainder 0.
  always_comb begin
    early_hit = 1'b0;
    early_acc = '0;
    if (op[2]) begin
      if (b_zero) begin
        early_hit = 1'b1;
        early_acc = {a_mag, {XLEN{1'b1}}};
      end else if (!op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}})) begin
        early_hit = 1'b1;
        early_acc = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
      end
    end else if ((a == '0) || b_zero) begin
      early_hit = 1'b1;
      early_acc = '0;
    end
  end
`endif

  always_comb begin
    // Shift-add: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring division: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The trial needs a
    // 33rd bit because the shifted remainder can exceed XLEN bits.
    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    div_ge    = (div_trial >= {1'b0, opnd_q});
    div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
                 acc_q[XLEN-2:0], div_ge};
  end

  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = rem_neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      fix_result = op_q[1] ? rem_fix : quot_fix;
    end else begin
      fix_result = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    fix_d     = fix_q;
    result_d  = result_q;

    req_ready  = rst_n && (state_q == IDLE) && !flush;
    resp_valid = (state_q == DONE);
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d      = op;
          rem_neg_d = a_neg;
          cnt_d     = '0;
          fix_d     = 1'b0;
          if (op[2]) begin
            // A zero divisor leaves the all-ones quotient un-negated.
            neg_d   = (a_neg ^ b_neg) && !b_zero;
            opnd_d  = b_mag;
            acc_d   = {{XLEN{1'b0}}, a_mag};
            state_d = DIV;
          end else begin
            neg_d   = a_neg ^ b_neg;
            opnd_d  = a_mag;
            acc_d   = {{XLEN{1'b0}}, b_mag};
            state_d = MUL;
          end
`ifdef MULDIV_EARLY_OUT_EN
          if (early_hit) begin
            acc_d = early_acc;
            fix_d = 1'b1;
          end
`endif
        end
      end

      MUL, DIV: begin
        if (fix_q) begin
          result_d = fix_result;
          fix_d    = 1'b0;
          state_d  = DONE;
        end else begin
          acc_d = (state_q == MUL) ? mul_next : div_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            fix_d = 1'b1;
          end
        end
      end

      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      fix_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      fix_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      fix_q     <= fix_d;
      result_q  <= result_d;
    end
  end

  assign result = result_q;

endmodule
